// File: rtl/word_stacker.sv
// Purpose : packs 32-bit words into 128-bit blocks (first word -> [127:96]), flush zero-pads a partial block.
// Latency : a block is valid the cycle after its 4th (or flushed) word is accepted; 1 word/cycle sustained.
// Backpr. : ready_o follows ready_i combinationally while a block is held; enable_i low blocks both sides.
//
// Ports: clk_i/rst_ni (async active-low), clr_i (sync clear, beats enable_i), enable_i (global hold),
//        valid_i/ready_o/word_i/flush_i (word input), valid_o/ready_i/word_o/padded_o (block output),
//        blocks_o (wrapping count of blocks handed off).
module word_stacker (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         enable_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [31:0]  word_i,
    input  logic         flush_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] word_o,
    output logic         padded_o,
    output logic [15:0]  blocks_o
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e         state_q;
    logic [1:0]     cnt_q;
    logic [127:0]   block_q;
    logic           padded_q;
    logic [15:0]    blocks_q;

    logic           acc;
    logic           out;
    logic [127:0]   block_fill;   // current slot written, rest untouched
    logic [127:0]   block_flush;  // current slot written, slots above zeroed
    logic [127:0]   block_pad;    // current slot and everything above zeroed

    // Full throughput needs the held block to leave in the same cycle a new
    // word arrives, hence the combinational ready_i -> ready_o path.
    assign ready_o  = enable_i & ((state_q == FILL) | ready_i);
    assign valid_o  = enable_i & (state_q == FULL);
    assign acc      = enable_i & valid_i & ready_o;
    assign out      = enable_i & valid_o & ready_i;
    assign word_o   = (state_q == FULL) ? block_q : 128'h0;
    assign padded_o = padded_q;
    assign blocks_o = blocks_q;

    always_comb begin
        block_fill  = block_q;
        block_flush = block_q;
        block_pad   = block_q;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) == cnt_q) begin
                block_fill[127-32*k -: 32]  = word_i;
                block_flush[127-32*k -: 32] = word_i;
                block_pad[127-32*k -: 32]   = 32'h0;
            end else if (2'(k) > cnt_q) begin
                block_flush[127-32*k -: 32] = 32'h0;
                block_pad[127-32*k -: 32]   = 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= FILL;
            cnt_q    <= 2'd0;
            block_q  <= 128'h0;
            padded_q <= 1'b0;
            blocks_q <= 16'h0;
        end else if (clr_i) begin
            state_q  <= FILL;
            cnt_q    <= 2'd0;
            block_q  <= 128'h0;
            padded_q <= 1'b0;
            blocks_q <= 16'h0;
        end else if (enable_i) begin
            case (state_q)
                FILL: begin
                    if (acc) begin
                        if (flush_i) begin
                            block_q  <= block_flush;
                            state_q  <= FULL;
                            padded_q <= (cnt_q != 2'd3);
                            cnt_q    <= 2'd0;
                        end else begin
                            block_q <= block_fill;
                            if (cnt_q == 2'd3) begin
                                state_q  <= FULL;
                                padded_q <= 1'b0;
                                cnt_q    <= 2'd0;
                            end else begin
                                cnt_q <= cnt_q + 2'd1;
                            end
                        end
                    end else if (flush_i && cnt_q != 2'd0) begin
                        // An empty block is never emitted, so cnt_q==0 flushes are ignored.
                        block_q  <= block_pad;
                        state_q  <= FULL;
                        padded_q <= 1'b1;
                        cnt_q    <= 2'd0;
                    end
                end
                FULL: begin
                    if (out) begin
                        blocks_q <= blocks_q + 16'd1;
                        if (acc) begin
                            // Handoff and next word in one cycle: word lands in slot 0.
                            block_q <= {word_i, 96'h0};
                            if (flush_i) begin
                                state_q  <= FULL;
                                padded_q <= 1'b1;
                                cnt_q    <= 2'd0;
                            end else begin
                                state_q  <= FILL;
                                padded_q <= 1'b0;
                                cnt_q    <= 2'd1;
                            end
                        end else begin
                            block_q  <= 128'h0;
                            state_q  <= FILL;
                            padded_q <= 1'b0;
                            cnt_q    <= 2'd0;
                        end
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule
